// File: rtl/dma_queue_seq.sv
// Descriptor-queue sequencer: buffers 9-byte DMA descriptors written by the Z80
// and replays each one onto the DMA register strobes, ending with the launch write.
module dma_queue_seq #(
    parameter int unsigned FIFO_AW = 6,
    parameter int unsigned ACT_TMO = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       q_wr,
    input  logic [7:0] q_data,
    input  logic       q_flush,
    input  logic       dma_act,
    output logic [8:0] dmaport_wr,
    output logic [7:0] zdata,
    output logic       seq_own,
    output logic       busy,
    output logic       q_empty,
    output logic       q_full,
    output logic       q_ovf,
    output logic [2:0] desc_cnt,
    output logic       seq_int
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned TW    = (ACT_TMO > 1) ? $clog2(ACT_TMO) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT_ACT, S_WAIT, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic [3:0]         widx_q, widx_d, ridx_q, ridx_d;
    logic [2:0]         desc_q, desc_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic               ovf_q, ovf_d, pend_q, pend_d, sup_q, sup_d;
    logic [8:0]         wr_q, wr_d;
    logic [7:0]         zd_q, zd_d;
    logic               own_q, own_d, int_q, int_d;
    logic [7:0]         mem [DEPTH];
    logic               full, push, pop, desc_inc, desc_dec, apply;

    always_comb begin
        full     = (cnt_q == (FIFO_AW+1)'(DEPTH));
        push     = q_wr && !full && !q_flush;
        pop      = (state_q == S_LOAD);
        state_d  = state_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        cnt_d    = cnt_q;
        widx_d   = widx_q;
        ridx_d   = ridx_q;
        tmo_d    = tmo_q;
        ovf_d    = ovf_q;
        pend_d   = pend_q;
        sup_d    = sup_q;
        wr_d     = '0;
        zd_d     = '0;
        own_d    = 1'b0;
        desc_inc = push && (widx_q == 4'd8);
        desc_dec = 1'b0;
        apply    = 1'b0;

        if (push) begin
            wptr_d = wptr_q + 1'b1;
            widx_d = (widx_q == 4'd8) ? '0 : widx_q + 4'd1;
        end
        if (q_wr && full && !q_flush) ovf_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (desc_q != '0 && !dma_act && !q_flush) begin
                    state_d  = S_LOAD;
                    ridx_d   = '0;
                    desc_dec = 1'b1;
                    sup_d    = 1'b0;
                end
            end
            S_LOAD: begin
                own_d  = 1'b1;
                zd_d   = mem[rptr_q];
                rptr_d = rptr_q + 1'b1;
                case (ridx_q)
                    4'd6:    wr_d = 9'h040;
                    4'd7:    wr_d = 9'h100;
                    4'd8:    wr_d = 9'h080;
                    default: wr_d = 9'd1 << ridx_q;
                endcase
                if (q_flush) pend_d = 1'b1;
                // A flush seen mid-descriptor takes effect only once the launch byte is out
                if (ridx_q == 4'd8) begin
                    state_d = S_WAIT_ACT;
                    tmo_d   = '0;
                    apply   = q_flush || pend_q;
                end else begin
                    ridx_d = ridx_q + 4'd1;
                end
            end
            S_WAIT_ACT: begin
                if (dma_act)                            state_d = S_WAIT;
                else if (tmo_q == TW'(ACT_TMO - 1))     state_d = S_DONE;
                else                                    tmo_d   = tmo_q + 1'b1;
            end
            S_WAIT:  if (!dma_act) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_LOAD && q_flush) apply = 1'b1;

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        desc_d = desc_q + {2'b00, desc_inc} - {2'b00, desc_dec};

        if (apply) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            widx_d = '0;
            desc_d = '0;
            ovf_d  = 1'b0;
            pend_d = 1'b0;
            if (state_q != S_IDLE) sup_d = 1'b1;
        end

        int_d = (state_d == S_DONE) && (desc_d == '0) && !sup_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            widx_q  <= '0;
            ridx_q  <= '0;
            desc_q  <= '0;
            tmo_q   <= '0;
            ovf_q   <= 1'b0;
            pend_q  <= 1'b0;
            sup_q   <= 1'b0;
            wr_q    <= '0;
            zd_q    <= '0;
            own_q   <= 1'b0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            ridx_q  <= ridx_d;
            desc_q  <= desc_d;
            tmo_q   <= tmo_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
            sup_q   <= sup_d;
            wr_q    <= wr_d;
            zd_q    <= zd_d;
            own_q   <= own_d;
            int_q   <= int_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= q_data;
    end

    assign dmaport_wr = wr_q;
    assign zdata      = zd_q;
    assign seq_own    = own_q;
    assign seq_int    = int_q;
    assign q_ovf      = ovf_q;
    assign desc_cnt   = desc_q;
    assign q_empty    = (cnt_q == '0);
    assign q_full     = full;
    assign busy       = (state_q != S_IDLE) || (desc_q != '0);
endmodule
